// File: rtl/mouse_event_decoder.sv
// mouse_event_decoder
//   Turns the PS/2 mouse wrapper's pixel position, button levels and
//   new_event strobe into character-cell coordinates and discrete UI events
//   (click, double-click, drag start/move/end, right-click) for the editor.
//
// Ports
//   clk              pixel clock
//   rst              synchronous active-high reset
//   mouse_x/mouse_y  cursor position in pixels (10 bits each)
//   mouse_left/right button levels, valid when mouse_new_event=1
//   mouse_new_event  one-cycle sample strobe
//   evt_valid        one-cycle event strobe, one cycle after the sample
//   evt_code         0 NONE, 1 CLICK, 2 DOUBLE, 3 DRAG_START, 4 DRAG_MOVE,
//                    5 DRAG_END, 6 RIGHT_CLICK (held until the next event)
//   evt_col/evt_row  cell the event refers to
//   hover_col/row    cell under the cursor at the last sample
module mouse_event_decoder #(
  parameter int CLK_HZ       = 108000000,
  parameter int DBL_CLICK_MS = 400,
  parameter int CELL_W_LOG2  = 3,
  parameter int CELL_H_LOG2  = 4,
  parameter int COLS         = 80,
  parameter int ROWS         = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] mouse_x,
  input  logic [9:0] mouse_y,
  input  logic       mouse_left,
  input  logic       mouse_right,
  input  logic       mouse_new_event,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  output logic [6:0] evt_col,
  output logic [5:0] evt_row,
  output logic [6:0] hover_col,
  output logic [5:0] hover_row
);

  localparam int TMR_LOAD = CLK_HZ / 1000 * DBL_CLICK_MS;
  localparam int TMR_W    = $clog2(TMR_LOAD + 1);

  localparam logic [2:0] EV_CLICK      = 3'd1;
  localparam logic [2:0] EV_DOUBLE     = 3'd2;
  localparam logic [2:0] EV_DRAG_START = 3'd3;
  localparam logic [2:0] EV_DRAG_MOVE  = 3'd4;
  localparam logic [2:0] EV_DRAG_END   = 3'd5;
  localparam logic [2:0] EV_RIGHT      = 3'd6;

  typedef enum logic [1:0] {IDLE, PRESS, DRAG} state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             prev_left_q, prev_left_d;
  logic             prev_right_q, prev_right_d;
  logic [6:0]       press_col_q, press_col_d;
  logic [5:0]       press_row_q, press_row_d;
  logic [6:0]       drag_col_q, drag_col_d;
  logic [5:0]       drag_row_q, drag_row_d;
  logic [6:0]       click_col_q, click_col_d;
  logic [5:0]       click_row_q, click_row_d;
  logic             evt_valid_q, evt_valid_d;
  logic [2:0]       evt_code_q, evt_code_d;
  logic [6:0]       evt_col_q, evt_col_d;
  logic [5:0]       evt_row_q, evt_row_d;
  logic [6:0]       hover_col_q, hover_col_d;
  logic [5:0]       hover_row_q, hover_row_d;

  logic [9:0] x_cells, y_cells;
  logic [6:0] cur_col;
  logic [5:0] cur_row;
  logic       left_rise, right_rise;
  logic       press_moved, drag_moved, armed;
  logic       tmr_load, tmr_clear;

  // Pixel to cell conversion; the clamp compares the full 10-bit quotient so
  // positions past the last column/row never wrap after truncation.
  always_comb begin
    x_cells = mouse_x >> CELL_W_LOG2;
    y_cells = mouse_y >> CELL_H_LOG2;
    cur_col = (x_cells > 10'(COLS - 1)) ? 7'(COLS - 1) : x_cells[6:0];
    cur_row = (y_cells > 10'(ROWS - 1)) ? 6'(ROWS - 1) : y_cells[5:0];
  end

  assign left_rise   = mouse_left & ~prev_left_q;
  assign right_rise  = mouse_right & ~prev_right_q;
  assign press_moved = (cur_col != press_col_q) || (cur_row != press_row_q);
  assign drag_moved  = (cur_col != drag_col_q) || (cur_row != drag_row_q);
  assign armed       = (timer_q != '0);

  // Next-state and event selection; only sample cycles change anything
  // except the free-running double-click timer handled below.
  always_comb begin
    state_d      = state_q;
    prev_left_d  = prev_left_q;
    prev_right_d = prev_right_q;
    press_col_d  = press_col_q;
    press_row_d  = press_row_q;
    drag_col_d   = drag_col_q;
    drag_row_d   = drag_row_q;
    click_col_d  = click_col_q;
    click_row_d  = click_row_q;
    evt_valid_d  = 1'b0;
    evt_code_d   = evt_code_q;
    evt_col_d    = evt_col_q;
    evt_row_d    = evt_row_q;
    hover_col_d  = hover_col_q;
    hover_row_d  = hover_row_q;
    tmr_load     = 1'b0;
    tmr_clear    = 1'b0;

    if (mouse_new_event) begin
      prev_left_d  = mouse_left;
      prev_right_d = mouse_right;
      hover_col_d  = cur_col;
      hover_row_d  = cur_row;
      unique case (state_q)
        IDLE: begin
          if (left_rise) begin
            press_col_d = cur_col;
            press_row_d = cur_row;
            state_d     = PRESS;
          end else if (right_rise) begin
            evt_valid_d = 1'b1;
            evt_code_d  = EV_RIGHT;
            evt_col_d   = cur_col;
            evt_row_d   = cur_row;
          end
        end
        PRESS: begin
          if (mouse_left) begin
            if (press_moved) begin
              evt_valid_d = 1'b1;
              evt_code_d  = EV_DRAG_START;
              evt_col_d   = press_col_q;
              evt_row_d   = press_row_q;
              drag_col_d  = cur_col;
              drag_row_d  = cur_row;
              tmr_clear   = 1'b1;
              state_d     = DRAG;
            end
          end else begin
            evt_valid_d = 1'b1;
            evt_col_d   = press_col_q;
            evt_row_d   = press_row_q;
            state_d     = IDLE;
            // A DOUBLE consumes the window so a third click starts afresh.
            if (armed && press_col_q == click_col_q && press_row_q == click_row_q) begin
              evt_code_d = EV_DOUBLE;
              tmr_clear  = 1'b1;
            end else begin
              evt_code_d  = EV_CLICK;
              click_col_d = press_col_q;
              click_row_d = press_row_q;
              tmr_load    = 1'b1;
            end
          end
        end
        DRAG: begin
          if (mouse_left) begin
            if (drag_moved) begin
              evt_valid_d = 1'b1;
              evt_code_d  = EV_DRAG_MOVE;
              evt_col_d   = cur_col;
              evt_row_d   = cur_row;
              drag_col_d  = cur_col;
              drag_row_d  = cur_row;
            end
          end else begin
            evt_valid_d = 1'b1;
            evt_code_d  = EV_DRAG_END;
            evt_col_d   = cur_col;
            evt_row_d   = cur_row;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Double-click window counts down every clock and saturates at zero;
  // a load takes priority over the decrement.
  always_comb begin
    if (tmr_load) begin
      timer_d = TMR_W'(TMR_LOAD);
    end else if (tmr_clear || timer_q == '0) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q - TMR_W'(1);
    end
  end

  // Register bank; reset discards any sample arriving in the same cycle and
  // abandons a drag without reporting DRAG_END.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      prev_left_q  <= 1'b0;
      prev_right_q <= 1'b0;
      press_col_q  <= '0;
      press_row_q  <= '0;
      drag_col_q   <= '0;
      drag_row_q   <= '0;
      click_col_q  <= '0;
      click_row_q  <= '0;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= '0;
      evt_col_q    <= '0;
      evt_row_q    <= '0;
      hover_col_q  <= '0;
      hover_row_q  <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      prev_left_q  <= prev_left_d;
      prev_right_q <= prev_right_d;
      press_col_q  <= press_col_d;
      press_row_q  <= press_row_d;
      drag_col_q   <= drag_col_d;
      drag_row_q   <= drag_row_d;
      click_col_q  <= click_col_d;
      click_row_q  <= click_row_d;
      evt_valid_q  <= evt_valid_d;
      evt_code_q   <= evt_code_d;
      evt_col_q    <= evt_col_d;
      evt_row_q    <= evt_row_d;
      hover_col_q  <= hover_col_d;
      hover_row_q  <= hover_row_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign evt_col   = evt_col_q;
  assign evt_row   = evt_row_q;
  assign hover_col = hover_col_q;
  assign hover_row = hover_row_q;

endmodule

// File: tb/tb_mouse_event_decoder.sv
// tb_mouse_event_decoder
//   Directed scenarios followed by randomized mouse traffic, every cycle
//   compared against a behavioural model of the decoder. The double-click
//   window is modelled as a timestamp of the last CLICK edge rather than a
//   counter.
module tb_mouse_event_decoder;

  localparam int LOAD = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] mouse_x = '0;
  logic [9:0] mouse_y = '0;
  logic       mouse_left = 1'b0;
  logic       mouse_right = 1'b0;
  logic       mouse_new_event = 1'b0;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic [6:0] evt_col;
  logic [5:0] evt_row;
  logic [6:0] hover_col;
  logic [5:0] hover_row;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int  edge_n = 0;
  int  click_edge = -1000000;
  bit  pressed = 0, dragging = 0;
  bit  p_left = 0, p_right = 0;
  int  press_c = 0, press_r = 0;
  int  last_c = 0, last_r = 0;
  int  click_c = 0, click_r = 0;
  bit  m_valid = 0;
  int  m_code = 0, m_col = 0, m_row = 0;
  int  m_hcol = 0, m_hrow = 0;

  mouse_event_decoder #(
    .CLK_HZ(1000), .DBL_CLICK_MS(20), .CELL_W_LOG2(3), .CELL_H_LOG2(4),
    .COLS(80), .ROWS(64)
  ) dut (
    .clk(clk), .rst(rst),
    .mouse_x(mouse_x), .mouse_y(mouse_y),
    .mouse_left(mouse_left), .mouse_right(mouse_right),
    .mouse_new_event(mouse_new_event),
    .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_col(evt_col), .evt_row(evt_row),
    .hover_col(hover_col), .hover_row(hover_row)
  );

  // Free-running pixel clock
  always #5 clk = ~clk;

  // Record an event produced by the model for this edge
  task automatic emit(input int code, input int c, input int r);
    m_valid = 1;
    m_code  = code;
    m_col   = c;
    m_row   = r;
  endtask

  // Apply the decoder rules to one clock edge
  task automatic modelStep(input int x, input int y, input bit l, input bit r,
                           input bit ns, input bit rs);
    int  cc, cr;
    bit  lr, rr;
    edge_n++;
    m_valid = 0;
    if (rs) begin
      pressed = 0; dragging = 0; p_left = 0; p_right = 0;
      press_c = 0; press_r = 0; last_c = 0; last_r = 0;
      click_c = 0; click_r = 0; click_edge = -1000000;
      m_code = 0; m_col = 0; m_row = 0; m_hcol = 0; m_hrow = 0;
      return;
    end
    if (!ns) return;
    cc = (x / 8 > 79) ? 79 : x / 8;
    cr = (y / 16 > 63) ? 63 : y / 16;
    lr = l && !p_left;
    rr = r && !p_right;
    if (dragging) begin
      if (!l) begin
        emit(5, cc, cr);
        dragging = 0;
      end else if (cc != last_c || cr != last_r) begin
        emit(4, cc, cr);
        last_c = cc; last_r = cr;
      end
    end else if (pressed) begin
      if (l) begin
        if (cc != press_c || cr != press_r) begin
          emit(3, press_c, press_r);
          last_c = cc; last_r = cr;
          pressed = 0; dragging = 1;
          click_edge = -1000000;
        end
      end else begin
        pressed = 0;
        if ((edge_n - click_edge) <= LOAD && press_c == click_c && press_r == click_r) begin
          emit(2, press_c, press_r);
          click_edge = -1000000;
        end else begin
          emit(1, press_c, press_r);
          click_c = press_c; click_r = press_r;
          click_edge = edge_n;
        end
      end
    end else if (lr) begin
      press_c = cc; press_r = cr;
      pressed = 1;
    end else if (rr) begin
      emit(6, cc, cr);
    end
    p_left = l; p_right = r;
    m_hcol = cc; m_hrow = cr;
  endtask

  // Compare every output with the model, one cycle after the edge
  task automatic checkOutput();
    total += 6;
    assert (evt_valid === m_valid) else begin
      bad++; $error("[TB] FAIL evt_valid edge=%0d got=%0d want=%0d", edge_n, evt_valid, m_valid);
    end
    assert (evt_code === 3'(m_code)) else begin
      bad++; $error("[TB] FAIL evt_code edge=%0d got=%0d want=%0d", edge_n, evt_code, m_code);
    end
    assert (evt_col === 7'(m_col)) else begin
      bad++; $error("[TB] FAIL evt_col edge=%0d got=%0d want=%0d", edge_n, evt_col, m_col);
    end
    assert (evt_row === 6'(m_row)) else begin
      bad++; $error("[TB] FAIL evt_row edge=%0d got=%0d want=%0d", edge_n, evt_row, m_row);
    end
    assert (hover_col === 7'(m_hcol)) else begin
      bad++; $error("[TB] FAIL hover_col edge=%0d got=%0d want=%0d", edge_n, hover_col, m_hcol);
    end
    assert (hover_row === 6'(m_hrow)) else begin
      bad++; $error("[TB] FAIL hover_row edge=%0d got=%0d want=%0d", edge_n, hover_row, m_hrow);
    end
  endtask

  // Drive one cycle of inputs, advance the model and check after the edge
  task automatic applyStimulus(input int x, input int y, input bit l, input bit r,
                               input bit ns, input bit rs);
    mouse_x         = 10'(x);
    mouse_y         = 10'(y);
    mouse_left      = l;
    mouse_right     = r;
    mouse_new_event = ns;
    rst             = rs;
    modelStep(x, y, l, r, ns, rs);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, mouse_left, mouse_right, 0, 0);
  endtask

  // Sample with a one-cycle gap afterwards so each strobe is isolated
  task automatic sample(input int x, input int y, input bit l, input bit r);
    applyStimulus(x, y, l, r, 1, 0);
    idle(1);
  endtask

  initial begin
    int  x, y, gap;
    bit  l, r;

    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    idle(2);

    $display("[TB] hover and clamp");
    sample(1023, 1023, 0, 0);
    sample(17, 40, 0, 0);

    $display("[TB] single click");
    sample(100, 50, 1, 0);
    idle(3);
    sample(100, 50, 0, 0);
    idle(LOAD + 5);

    $display("[TB] double click, then slow second click");
    sample(100, 50, 1, 0);
    sample(100, 50, 0, 0);
    sample(100, 50, 1, 0);
    idle(2);
    sample(100, 50, 0, 0);
    sample(100, 50, 1, 0);
    sample(100, 50, 0, 0);
    sample(100, 50, 1, 0);
    idle(25);
    sample(100, 50, 0, 0);
    idle(LOAD + 5);

    $display("[TB] drag sequence");
    sample(8, 16, 1, 0);
    sample(24, 16, 1, 0);
    sample(24, 16, 1, 0);
    sample(40, 16, 1, 0);
    sample(40, 32, 0, 0);

    $display("[TB] right click and right press during drag");
    sample(0, 0, 0, 1);
    sample(0, 0, 0, 0);
    sample(8, 16, 1, 0);
    sample(24, 16, 1, 0);
    sample(24, 16, 1, 1);
    sample(40, 16, 0, 0);
    sample(40, 16, 0, 0);

    $display("[TB] reset mid-drag");
    sample(8, 16, 1, 0);
    sample(200, 100, 1, 0);
    applyStimulus(300, 200, 1, 0, 1, 1);
    idle(1);
    sample(300, 200, 0, 0);
    idle(2);

    $display("[TB] randomized traffic");
    l = 0; r = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) l = ~l;
      if ($urandom_range(0, 5) == 0) r = ~r;
      x = ($urandom_range(0, 9) == 0) ? 1023 : $urandom_range(0, 31);
      y = ($urandom_range(0, 9) == 0) ? 1023 : $urandom_range(0, 40);
      applyStimulus(x, y, l, r, ($urandom_range(0, 1) == 1), ($urandom_range(0, 79) == 0));
      if ($urandom_range(0, 7) == 0) begin
        gap = $urandom_range(0, 25);
        idle(gap);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
